// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//
// Captures the final score when a game ends and keeps the best score seen since
// reset. The selected value (final or high score) is converted to BCD digits
// by a sequential double-dabble engine that performs one shift step per clock.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   score        live score count from the game FSM
//   game_end     level, high while the game is over
//   show_high    1 = display high score, 0 = display final score
//   bcd_hundreds hundreds digit of the converted value
//   bcd_tens     tens digit
//   bcd_ones     ones digit
//   bcd_valid    digits are valid for the current selection
//   busy         conversion in progress
//   high_score   best score since reset
//   new_record   the last completed game set a new high score
// -----------------------------------------------------------------------------
module score_keeper #(
  parameter int SCORE_W    = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               game_end,
  input  logic               show_high,
  output logic [3:0]         bcd_hundreds,
  output logic [3:0]         bcd_tens,
  output logic [3:0]         bcd_ones,
  output logic               bcd_valid,
  output logic               busy,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_record
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W) + 1;
  localparam int ACC_W = BCD_W + SCORE_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, src}
  // left by one so the source MSB enters the BCD LSB.
  function automatic logic [ACC_W-1:0] dd_step(input logic [BCD_W-1:0]   bcd,
                                               input logic [SCORE_W-1:0] src);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = adj[4*i +: 4];
      end
    end
    return {adj[BCD_W-2:0], src, 1'b0};
  endfunction

  state_t             state_r;
  logic [SCORE_W-1:0] final_score_r;
  logic               prev_game_end_r;
  logic               prev_show_high_r;
  logic               pending_r;
  logic [SCORE_W-1:0] src_r;
  logic [BCD_W-1:0]   bcd_acc_r;
  logic [CNT_W-1:0]   step_cnt_r;

  logic               rise_s;
  logic               fall_s;
  logic               sel_chg_s;
  logic               last_step_s;
  logic [SCORE_W-1:0] max_s;
  logic [SCORE_W-1:0] rise_sel_s;
  logic [SCORE_W-1:0] cur_sel_s;
  logic               start_s;
  logic [SCORE_W-1:0] start_val_s;
  logic [ACC_W-1:0]   step_s;

  // Edge detection, selection muxes and the start-request decision.
  always_comb begin
    rise_s      = game_end & ~prev_game_end_r;
    fall_s      = ~game_end & prev_game_end_r;
    sel_chg_s   = game_end & (show_high ^ prev_show_high_r);
    last_step_s = (step_cnt_r == CNT_W'(SCORE_W - 1));
    step_s      = dd_step(bcd_acc_r, src_r);

    if (score > high_score) begin
      max_s = score;
    end else begin
      max_s = high_score;
    end

    // At the game-end edge the registers are not yet updated, so the high
    // score view must be computed from the incoming score.
    if (show_high) begin
      rise_sel_s = max_s;
      cur_sel_s  = high_score;
    end else begin
      rise_sel_s = score;
      cur_sel_s  = final_score_r;
    end

    // A selection change landing on the final step counts as pending too,
    // so the result shown always matches the latest selection.
    start_s     = 1'b0;
    start_val_s = cur_sel_s;
    if (rise_s) begin
      start_s     = 1'b1;
      start_val_s = rise_sel_s;
    end else if (state_r == ST_IDLE) begin
      start_s = sel_chg_s;
    end else if (last_step_s) begin
      start_s = pending_r | sel_chg_s;
    end else begin
      start_s = 1'b0;
    end
  end

  // Score capture, edge history and the conversion FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      final_score_r    <= {SCORE_W{1'b0}};
      high_score       <= {SCORE_W{1'b0}};
      prev_game_end_r  <= 1'b0;
      prev_show_high_r <= 1'b0;
      pending_r        <= 1'b0;
      src_r            <= {SCORE_W{1'b0}};
      bcd_acc_r        <= {BCD_W{1'b0}};
      step_cnt_r       <= {CNT_W{1'b0}};
      bcd_hundreds     <= 4'd0;
      bcd_tens         <= 4'd0;
      bcd_ones         <= 4'd0;
      bcd_valid        <= 1'b0;
      busy             <= 1'b0;
      new_record       <= 1'b0;
    end else begin
      prev_game_end_r  <= game_end;
      prev_show_high_r <= show_high;

      if (rise_s) begin
        final_score_r <= score;
        high_score    <= max_s;
        new_record    <= (score > high_score);
      end else if (fall_s) begin
        new_record <= 1'b0;
      end else begin
        new_record <= new_record;
      end

      if (fall_s) begin
        // Game restarted: abort any conversion and blank the display.
        state_r      <= ST_IDLE;
        pending_r    <= 1'b0;
        busy         <= 1'b0;
        bcd_valid    <= 1'b0;
        bcd_hundreds <= 4'd0;
        bcd_tens     <= 4'd0;
        bcd_ones     <= 4'd0;
      end else if (start_s) begin
        state_r    <= ST_CONV;
        src_r      <= start_val_s;
        bcd_acc_r  <= {BCD_W{1'b0}};
        step_cnt_r <= {CNT_W{1'b0}};
        pending_r  <= 1'b0;
        busy       <= 1'b1;
        bcd_valid  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_CONV: begin
            bcd_acc_r  <= step_s[ACC_W-1:SCORE_W];
            src_r      <= step_s[SCORE_W-1:0];
            step_cnt_r <= step_cnt_r + CNT_W'(1);
            if (last_step_s) begin
              state_r      <= ST_IDLE;
              busy         <= 1'b0;
              bcd_valid    <= 1'b1;
              bcd_hundreds <= step_s[SCORE_W+11:SCORE_W+8];
              bcd_tens     <= step_s[SCORE_W+7:SCORE_W+4];
              bcd_ones     <= step_s[SCORE_W+3:SCORE_W];
            end else if (sel_chg_s) begin
              pending_r <= 1'b1;
            end else begin
              pending_r <= pending_r;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
